// File: rtl/axi_lite_sram_responder.sv
// ============================================================================
// axi_lite_sram_responder : AXI4-Lite slave over a word-addressed SRAM array
// Optional macro AXI_SRAM_RAND_DELAY_EN adds 0-7 LFSR-driven latency cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_lite_sram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  DEC   = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_t;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  rstate_t     r_state;
  logic [31:0] r_addr;
  logic [15:0] r_cnt;
  wstate_t     w_state;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_held;
  logic        w_held;
  logic [15:0] w_cnt;
  logic [15:0] extra;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign extra = {13'd0, lfsr[2:0]};
`else
  assign extra = 16'd0;
`endif

  logic [15:0] rd_load;
  logic [15:0] wr_load;
  assign rd_load = 16'(RD_LAT - 1) + extra;
  assign wr_load = 16'(WR_LAT - 1) + extra;

  logic        w_commit;
  logic        w_in;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] merged;
  logic        r_in;
  logic [IDX_W-1:0] r_idx;
  logic [31:0] rd_word;
  logic        aw_hs;
  logic        w_hs;

  assign w_commit = (w_state == W_WAIT) && (w_cnt == 16'd0);
  assign w_in     = in_range(aw_addr);
  assign w_idx    = word_idx(aw_addr);
  assign r_in     = in_range(r_addr);
  assign r_idx    = word_idx(r_addr);

  always_comb begin
    merged = mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_strb[b]) merged[8*b +: 8] = w_data[8*b +: 8];
    end
  end

  // Write-first bypass when a commit and a read sample hit the same word
  assign rd_word = (w_commit && w_in && (w_idx == r_idx)) ? merged : mem[r_idx];

  assign arready = (r_state == R_IDLE) && !reset;
  assign awready = (w_state == W_IDLE) && !aw_held && !reset;
  assign wready  = (w_state == W_IDLE) && !w_held && !reset;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Read channel; RD_LAT==1 also passes through R_WAIT with a zero count,
  // which yields rvalid exactly one edge after the AR handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_addr  <= 32'd0;
      r_cnt   <= 16'd0;
      rdata   <= 32'd0;
      rresp   <= OKAY;
      rvalid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          r_cnt   <= rd_load;
          r_state <= R_WAIT;
        end
        R_WAIT: if (r_cnt == 16'd0) begin
          rdata   <= r_in ? rd_word : 32'd0;
          rresp   <= r_in ? OKAY : DEC;
          rvalid  <= 1'b1;
          r_state <= R_RESP;
        end else begin
          r_cnt <= r_cnt - 16'd1;
        end
        R_RESP: if (rready) begin
          rvalid  <= 1'b0;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_addr <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_cnt   <= 16'd0;
      bresp   <= OKAY;
      bvalid  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_addr <= awaddr;
          if (w_hs) begin
            w_data <= wdata;
            w_strb <= wstrb;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_cnt   <= wr_load;
            w_state <= W_WAIT;
          end else begin
            aw_held <= aw_held || aw_hs;
            w_held  <= w_held || w_hs;
          end
        end
        W_WAIT: if (w_cnt == 16'd0) begin
          bresp   <= w_in ? OKAY : DEC;
          bvalid  <= 1'b1;
          w_state <= W_RESP;
        end else begin
          w_cnt <= w_cnt - 16'd1;
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array is never reset; w_commit is already low whenever reset is high
  always_ff @(posedge clock) begin
    if (w_commit && w_in) mem[w_idx] <= merged;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_sram_responder.sv
// ============================================================================
// tb_axi_lite_sram_responder : directed bench with a cycle-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_sram_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          RDL   = 2;
  localparam int          WRL   = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_lite_sram_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RDL), .WR_LAT(WRL)
  ) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl [DEPTH];
  bit          rd_pend = 0, rd_fetched = 0;
  int          rd_due = 0;
  logic [31:0] rd_addr_m, exp_rdata;
  logic [1:0]  exp_rresp;
  bit          wr_busy = 0, wr_applied = 0, aw_got = 0, w_got = 0;
  int          wr_due = 0;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  exp_bresp;

  function automatic bit in_rng(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  always @(negedge clock) begin
    bit r_acc, w_acc;
    if (reset) begin
      rd_pend = 0; wr_busy = 0; aw_got = 0; w_got = 0;
    end else begin
      // a write committing on the read's sample edge is visible to that read
      if (wr_busy && !wr_applied && cyc == wr_due) begin
        if (in_rng(m_awaddr))
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) mdl[idx_of(m_awaddr)][8*b +: 8] = m_wdata[8*b +: 8];
        exp_bresp  = in_rng(m_awaddr) ? 2'b00 : 2'b11;
        wr_applied = 1;
      end
      if (rd_pend && !rd_fetched && cyc == rd_due) begin
        exp_rdata  = in_rng(rd_addr_m) ? mdl[idx_of(rd_addr_m)] : 32'd0;
        exp_rresp  = in_rng(rd_addr_m) ? 2'b00 : 2'b11;
        rd_fetched = 1;
      end
      chk("arready", 32'(arready), 32'(!rd_pend));
      chk("rvalid", 32'(rvalid), 32'(rd_pend && cyc >= rd_due));
      if (rd_pend && cyc >= rd_due) begin
        chk("rdata", rdata, exp_rdata);
        chk("rresp", 32'(rresp), 32'(exp_rresp));
      end
      chk("awready", 32'(awready), 32'(!wr_busy && !aw_got));
      chk("wready", 32'(wready), 32'(!wr_busy && !w_got));
      chk("bvalid", 32'(bvalid), 32'(wr_busy && cyc >= wr_due));
      if (wr_busy && cyc >= wr_due) chk("bresp", 32'(bresp), 32'(exp_bresp));

      r_acc = rd_pend && cyc >= rd_due && rready;
      if (!rd_pend && arvalid) begin
        rd_pend = 1; rd_fetched = 0; rd_addr_m = araddr; rd_due = cyc + 1 + RDL;
      end
      if (r_acc) rd_pend = 0;

      w_acc = wr_busy && cyc >= wr_due && bready;
      if (!wr_busy) begin
        if (awvalid && !aw_got) begin aw_got = 1; m_awaddr = awaddr; end
        if (wvalid && !w_got) begin w_got = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (aw_got && w_got) begin
          wr_busy = 1; wr_applied = 0; aw_got = 0; w_got = 0; wr_due = cyc + 1 + WRL;
        end
      end else if (w_acc) begin
        wr_busy = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic collect_r(input int hold, output logic [31:0] d, output logic [1:0] r, output int lat);
    lat = 0;
    forever begin
      @(negedge clock);
      if (rvalid) break;
      lat++;
      if (lat > 100) begin chk("r_timeout", 32'd1, 32'd0); break; end
    end
    repeat (hold) @(negedge clock);
    @(posedge clock); #1 rready = 1'b1;
    @(negedge clock); d = rdata; r = rresp;
    @(posedge clock); #1 rready = 1'b0;
  endtask

  task automatic collect_b(input int hold, output logic [1:0] r);
    int t;
    t = 0;
    do begin @(negedge clock); t++; end while (!bvalid && t < 100);
    if (!bvalid) chk("b_timeout", 32'd1, 32'd0);
    repeat (hold) @(negedge clock);
    @(posedge clock); #1 bready = 1'b1;
    @(negedge clock); r = bresp;
    @(posedge clock); #1 bready = 1'b0;
  endtask

  task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int hold, output logic [1:0] r);
    int t;
    bit awd, wd;
    awd = 0; wd = 0; t = 0;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0);
    while (!(awd && wd)) begin
      @(negedge clock);
      if (awvalid && awready) awd = 1;
      if (wvalid && wready) wd = 1;
      @(posedge clock); #1;
      t++;
      wvalid  = !wd;
      awvalid = !awd && (t >= w_lead);
      if (t > 100) begin chk("w_hs_timeout", 32'd1, 32'd0); break; end
    end
    wvalid = 1'b0; awvalid = 1'b0;
    collect_b(hold, r);
  endtask

  task automatic read_tx(input logic [31:0] a, input int hold,
                         output logic [31:0] d, output logic [1:0] r, output int lat);
    int t;
    t = 0;
    araddr = a; arvalid = 1'b1;
    forever begin
      @(negedge clock);
      if (arready) break;
      t++;
      if (t > 100) begin chk("ar_timeout", 32'd1, 32'd0); break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1 arvalid = 1'b0;
    collect_r(hold, d, r, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r, br;
    int          lat;

    #1;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock); #1;

    // write then read, with latency pinned to RD_LAT
    write_tx(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, br);
    chk("wr_bresp", 32'(br), 32'd0);
    read_tx(32'h8000_0010, 0, d, r, lat);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_rresp", 32'(r), 32'd0);
    chk("rd_latency", 32'(lat), 32'd2);

    // partial strobe
    write_tx(32'h8000_0020, 32'h1122_3344, 4'b1111, 0, 0, br);
    write_tx(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0, br);
    read_tx(32'h8000_0022, 0, d, r, lat);
    chk("strobe_data", d, 32'h11BB_33DD);

    // zero strobe in range: no update, OKAY
    write_tx(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, 0, br);
    chk("zstrb_bresp", 32'(br), 32'd0);
    read_tx(32'h8000_0010, 0, d, r, lat);
    chk("zstrb_data", d, 32'hDEAD_BEEF);

    // decode errors
    write_tx(32'h8000_0000, 32'h1234_5678, 4'b1111, 0, 0, br);
    read_tx(32'h7FFF_FFFC, 0, d, r, lat);
    chk("dec_rresp", 32'(r), 32'd3);
    chk("dec_rdata", d, 32'd0);
    write_tx(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'b1111, 0, 0, br);
    chk("dec_bresp", 32'(br), 32'd3);
    read_tx(32'h8000_0000, 0, d, r, lat);
    chk("word0_kept", d, 32'h1234_5678);
    read_tx(BASE + 32'(4 * DEPTH) - 32'd4, 0, d, r, lat);
    chk("top_word_rresp", 32'(r), 32'd0);

    // W three cycles ahead of AW, responses held off for five cycles
    write_tx(32'h8000_0030, 32'h0F0F_A5A5, 4'b1111, 3, 5, br);
    chk("bp_bresp", 32'(br), 32'd0);
    read_tx(32'h8000_0030, 5, d, r, lat);
    chk("bp_rdata", d, 32'h0F0F_A5A5);

    // collision: AR one edge before the write's handshake -> same edge commit/sample
    write_tx(32'h8000_0040, 32'h0102_0304, 4'b1111, 0, 0, br);
    araddr = 32'h8000_0040; arvalid = 1'b1;
    @(posedge clock); #1 arvalid = 1'b0;
    awaddr = 32'h8000_0040; wdata = 32'hCAFE_F00D; wstrb = 4'b0011;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clock); #1 awvalid = 1'b0; wvalid = 1'b0;
    collect_r(0, d, r, lat);
    chk("collide_rdata", d, 32'h0102_F00D);
    collect_b(0, br);
    chk("collide_bresp", 32'(br), 32'd0);

    // reset during R_WAIT
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clock); #1 arvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rwait_rst_rvalid", 32'(rvalid), 32'd0);
    chk("rwait_rst_arready", 32'(arready), 32'd0);
    chk("rwait_rst_awready", 32'(awready), 32'd0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_arready", 32'(arready), 32'd1);
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    @(posedge clock); #1;

    // reset while the response is on the bus must drop it asynchronously
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clock); #1 arvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rresp_pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rresp_rst_rvalid", 32'(rvalid), 32'd0);
    chk("rresp_rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock); #1;

    read_tx(32'h8000_0010, 0, d, r, lat);
    chk("after_rst_data", d, 32'hDEAD_BEEF);
    chk("after_rst_latency", 32'(lat), 32'd2);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
